rom_load_sequencer: RTL and testbench

ROM_LOAD_SEQUENCER -- requirements
Module: rom_load_sequencer

---
 rtl/rom_load_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_rom_load_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
// ------------------
// Boot sequencer for a ROM-image based system. It forwards the loader's byte
// stream to the EPROM stores with one register stage, tags each byte with the
// EPROM region it belongs to, and counts the bytes so a wrong-sized image can
// be flagged. After the download ends it zero-fills the first CLEAR_DEPTH bytes
// of work RAM, waits SETTLE_CYCLES idle cycles and then releases the CPUs.
// Re-asserting the download at any point after the load aborts back to LOAD
// and puts the CPUs straight back into reset.
//
// Parameters
//   EXPECTED_SIZE  byte count of a complete ROM image
//   CLEAR_DEPTH    work-RAM bytes zero-filled after a load (1..1024)
//   SETTLE_CYCLES  idle cycles between the clear and CPU release (>= 1)
//
// Ports
//   clk_i             system clock, all logic on the rising edge
//   reset_i           synchronous active-high reset, overrides every input
//   ioctl_download_i  high while the loader streams the image
//   ioctl_wr_i        one-cycle byte-valid strobe
//   ioctl_addr_i      byte address of ioctl_data_i
//   ioctl_data_i      download byte
//   rom_wr_o          registered EPROM write strobe
//   rom_addr_o        registered copy of the accepted address
//   rom_data_o        registered copy of the accepted byte
//   region_o          registered region index of rom_addr_o
//   wram_wr_o         work-RAM clear strobe
//   wram_addr_o       work-RAM clear address
//   wram_data_o       work-RAM clear data (always 0)
//   cpu_reset_o       holds CPU and audio CPU in reset
//   load_done_o       high while the system runs
//   size_err_o        last download byte count differed from EXPECTED_SIZE

module rom_load_sequencer #(
  parameter int EXPECTED_SIZE = 'h14960,
  parameter int CLEAR_DEPTH   = 1024,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ioctl_download_i,
  input  logic        ioctl_wr_i,
  input  logic [24:0] ioctl_addr_i,
  input  logic [7:0]  ioctl_data_i,
  output logic        rom_wr_o,
  output logic [24:0] rom_addr_o,
  output logic [7:0]  rom_data_o,
  output logic [2:0]  region_o,
  output logic        wram_wr_o,
  output logic [9:0]  wram_addr_o,
  output logic [7:0]  wram_data_o,
  output logic        cpu_reset_o,
  output logic        load_done_o,
  output logic        size_err_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CLEAR  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;

  localparam logic [24:0] BYTE_CNT_MAX = 25'h1FF_FFFF;
  localparam logic [24:0] EXPECTED_CNT = 25'(EXPECTED_SIZE);
  localparam logic [9:0]  CLEAR_LAST   = 10'(CLEAR_DEPTH - 1);
  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [24:0] byte_cnt_q, byte_cnt_d;
  logic [9:0]  clr_cnt_q, clr_cnt_d;
  logic [15:0] settle_cnt_q, settle_cnt_d;
  logic        size_err_q, size_err_d;
  logic        rom_wr_q, rom_wr_d;
  logic [24:0] rom_addr_q, rom_addr_d;
  logic [7:0]  rom_data_q, rom_data_d;
  logic [2:0]  region_q, region_d;
  logic        accept;

  // EPROM region boundaries; anything past the tone ROM lands in region 7
  // but is still forwarded so the loader never stalls on it.
  function automatic logic [2:0] region_of(input logic [24:0] a);
    logic [2:0] r;
    if      (a < 25'h10000) r = 3'd0;
    else if (a < 25'h14000) r = 3'd1;
    else if (a < 25'h14800) r = 3'd2;
    else if (a < 25'h14900) r = 3'd3;
    else if (a < 25'h14920) r = 3'd4;
    else if (a < 25'h14940) r = 3'd5;
    else if (a < 25'h14960) r = 3'd6;
    else                    r = 3'd7;
    return r;
  endfunction

  // Strobes are only honoured while in LOAD, including the cycle in which
  // the download drops, so the final byte of an image is never lost.
  assign accept = (state_q == S_LOAD) && ioctl_wr_i;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    clr_cnt_d    = clr_cnt_q;
    settle_cnt_d = settle_cnt_q;
    size_err_d   = size_err_q;
    rom_wr_d     = accept;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;
    region_d     = region_q;

    if (accept) begin
      rom_addr_d = ioctl_addr_i;
      rom_data_d = ioctl_data_i;
      region_d   = region_of(ioctl_addr_i);
      if (byte_cnt_q != BYTE_CNT_MAX) begin
        byte_cnt_d = byte_cnt_q + 25'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (ioctl_download_i) begin
          state_d    = S_LOAD;
          byte_cnt_d = '0;
          size_err_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (!ioctl_download_i) begin
          state_d    = S_CLEAR;
          clr_cnt_d  = '0;
          // byte_cnt_d already includes a strobe arriving in this cycle
          size_err_d = (byte_cnt_d != EXPECTED_CNT);
        end
      end
      S_CLEAR: begin
        if (ioctl_download_i) begin
          state_d    = S_LOAD;
          byte_cnt_d = '0;
          size_err_d = 1'b0;
        end else if (clr_cnt_q == CLEAR_LAST) begin
          state_d      = S_SETTLE;
          settle_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 10'd1;
        end
      end
      S_SETTLE: begin
        if (ioctl_download_i) begin
          state_d    = S_LOAD;
          byte_cnt_d = '0;
          size_err_d = 1'b0;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d = S_RUN;
        end else begin
          settle_cnt_d = settle_cnt_q + 16'd1;
        end
      end
      S_RUN: begin
        if (ioctl_download_i) begin
          state_d    = S_LOAD;
          byte_cnt_d = '0;
          size_err_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      clr_cnt_q    <= '0;
      settle_cnt_q <= '0;
      size_err_q   <= 1'b0;
      rom_wr_q     <= 1'b0;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
      region_q     <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      clr_cnt_q    <= clr_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      size_err_q   <= size_err_d;
      rom_wr_q     <= rom_wr_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      region_q     <= region_d;
    end
  end

  assign rom_wr_o    = rom_wr_q;
  assign rom_addr_o  = rom_addr_q;
  assign rom_data_o  = rom_data_q;
  assign region_o    = region_q;
  assign size_err_o  = size_err_q;
  // The clear address is forced to 0 outside CLEAR so idle outputs are quiet.
  assign wram_wr_o   = (state_q == S_CLEAR);
  assign wram_addr_o = (state_q == S_CLEAR) ? clr_cnt_q : 10'd0;
  assign wram_data_o = 8'd0;
  assign cpu_reset_o = (state_q != S_RUN);
  assign load_done_o = (state_q == S_RUN);

endmodule

// File: tb/tb_rom_load_sequencer.sv
module tb_rom_load_sequencer;

  localparam int EXP_SIZE = 'h200;
  localparam int CLR      = 1024;
  localparam int SETTLE   = 16;

  localparam logic [24:0] RA [6] = '{25'hFFFF, 25'h10000, 25'h147FF, 25'h14800, 25'h1491F, 25'h14960};
  localparam logic [7:0]  RD [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  localparam logic [2:0]  RR [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
  localparam int LIMITS [7] = '{'h10000, 'h14000, 'h14800, 'h14900, 'h14920, 'h14940, 'h14960};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dl = 1'b0;
  logic        wr = 1'b0;
  logic [24:0] addr = '0;
  logic [7:0]  data = '0;

  logic        rom_wr;
  logic [24:0] rom_addr;
  logic [7:0]  rom_data;
  logic [2:0]  region;
  logic        wram_wr;
  logic [9:0]  wram_addr;
  logic [7:0]  wram_data;
  logic        cpu_reset;
  logic        load_done;
  logic        size_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  rom_load_sequencer #(
    .EXPECTED_SIZE(EXP_SIZE),
    .CLEAR_DEPTH  (CLR),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .ioctl_download_i(dl),
    .ioctl_wr_i      (wr),
    .ioctl_addr_i    (addr),
    .ioctl_data_i    (data),
    .rom_wr_o        (rom_wr),
    .rom_addr_o      (rom_addr),
    .rom_data_o      (rom_data),
    .region_o        (region),
    .wram_wr_o       (wram_wr),
    .wram_addr_o     (wram_addr),
    .wram_data_o     (wram_data),
    .cpu_reset_o     (cpu_reset),
    .load_done_o     (load_done),
    .size_err_o      (size_err)
  );

  // Region = how many boundaries the address has reached or passed.
  function automatic logic [2:0] expect_region(input logic [24:0] a);
    int n;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      if (int'(a) >= LIMITS[i]) n++;
    end
    return 3'(n);
  endfunction

  // Model: phase 0 = idle, 1 = receiving bytes, 2 = post-load timeline where
  // m_since is cycles since the download ended (clear, then settle, then run).
  int          m_phase;
  int          m_bytes;
  int          m_since;
  logic        e_rom_wr;
  logic [24:0] e_rom_addr;
  logic [7:0]  e_rom_data;
  logic [2:0]  e_region;
  logic        e_size_err;
  logic        e_wram_wr;
  logic [9:0]  e_wram_addr;
  logic        e_run;

  initial begin
    m_phase = 0; m_bytes = 0; m_since = 0;
    e_rom_wr = 1'b0; e_rom_addr = '0; e_rom_data = '0; e_region = '0; e_size_err = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      e_wram_wr   = (m_phase == 2) && (m_since < CLR);
      e_wram_addr = e_wram_wr ? 10'(m_since) : 10'd0;
      e_run       = (m_phase == 2) && (m_since >= CLR + SETTLE);
      n_cmp++;
      if (rom_wr !== e_rom_wr || rom_addr !== e_rom_addr || rom_data !== e_rom_data ||
          region !== e_region || wram_wr !== e_wram_wr || wram_addr !== e_wram_addr ||
          wram_data !== 8'd0 || cpu_reset !== !e_run || load_done !== e_run ||
          size_err !== e_size_err) begin
        n_bad++;
        $display("FAIL model_cycle %0d: got rw=%b ra=%h rd=%h rg=%0d ww=%b wa=%0d wd=%h cr=%b ld=%b se=%b required rw=%b ra=%h rd=%h rg=%0d ww=%b wa=%0d wd=00 cr=%b ld=%b se=%b",
                 cyc, rom_wr, rom_addr, rom_data, region, wram_wr, wram_addr, wram_data,
                 cpu_reset, load_done, size_err, e_rom_wr, e_rom_addr, e_rom_data, e_region,
                 e_wram_wr, e_wram_addr, !e_run, e_run, e_size_err);
      end
      // advance the model with the inputs the next rising edge will sample
      e_rom_wr = 1'b0;
      if (reset) begin
        m_phase = 0; m_bytes = 0; m_since = 0;
        e_rom_addr = '0; e_rom_data = '0; e_region = '0; e_size_err = 1'b0;
      end else begin
        case (m_phase)
          0: begin
            if (dl) begin m_phase = 1; m_bytes = 0; e_size_err = 1'b0; end
          end
          1: begin
            if (wr) begin
              e_rom_wr = 1'b1; e_rom_addr = addr; e_rom_data = data;
              e_region = expect_region(addr);
              if (m_bytes < 'h1FFFFFF) m_bytes++;
            end
            if (!dl) begin
              e_size_err = (m_bytes != EXP_SIZE);
              m_phase = 2; m_since = 0;
            end
          end
          default: begin
            if (dl) begin m_phase = 1; m_bytes = 0; e_size_err = 1'b0; end
            else if (m_since < CLR + SETTLE) m_since++;
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    wr = 1'b1; addr = a; data = d;
    tick();
    wr = 1'b0;
    tick();
  endtask

  task automatic load_bytes(input int n);
    for (int i = 0; i < n; i++) strobe(25'(i), 8'(i * 7 + 3));
  endtask

  task automatic wait_run(output int pulses, output int settle);
    pulses = 0; settle = 0;
    for (int k = 0; k < 4000 && !load_done; k++) begin
      if (wram_wr) pulses++;
      else settle++;
      tick();
    end
    check("reach_run", 32'(load_done), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rom_wr"},    32'(rom_wr),    32'd0);
    check({tag, "_rom_addr"},  32'(rom_addr),  32'd0);
    check({tag, "_rom_data"},  32'(rom_data),  32'd0);
    check({tag, "_region"},    32'(region),    32'd0);
    check({tag, "_wram_wr"},   32'(wram_wr),   32'd0);
    check({tag, "_wram_addr"}, 32'(wram_addr), 32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_size_err"},  32'(size_err),  32'd0);
  endtask

  initial begin
    int p, s;
    reset = 1'b1;
    repeat (3) tick();
    check_reset_values("por");
    reset = 1'b0;
    tick();

    // strobe while idle is ignored
    wr = 1'b1; addr = 25'd5; data = 8'hAA;
    tick();
    wr = 1'b0;
    check("idle_wr_ignored", 32'(rom_wr), 32'd0);

    // region boundaries, one-cycle latency
    dl = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      wr = 1'b1; addr = RA[i]; data = RD[i];
      tick();
      wr = 1'b0;
      check("region_rom_wr", 32'(rom_wr), 32'd1);
      check("region_idx", 32'(region), 32'(RR[i]));
      check("region_data", 32'(rom_data), 32'(RD[i]));
      check("region_addr", 32'(rom_addr), 32'(RA[i]));
      tick();
    end
    dl = 1'b0;
    tick();
    check("six_byte_size_err", 32'(size_err), 32'd1);
    wait_run(p, s);

    // full load
    dl = 1'b1;
    tick();
    check("abort_run_cpu_reset", 32'(cpu_reset), 32'd1);
    check("load_entry_size_err", 32'(size_err), 32'd0);
    load_bytes(EXP_SIZE);
    dl = 1'b0;
    tick();
    check("full_size_err", 32'(size_err), 32'd0);
    wait_run(p, s);
    check("full_wram_pulses", 32'(p), 32'd1024);
    check("full_settle_cycles", 32'(s), 32'd16);
    check("full_cpu_reset", 32'(cpu_reset), 32'd0);
    check("full_load_done", 32'(load_done), 32'd1);

    // short load flags a size error
    dl = 1'b1;
    tick();
    load_bytes('h100);
    dl = 1'b0;
    tick();
    check("short_size_err", 32'(size_err), 32'd1);
    wait_run(p, s);
    check("short_size_err_run", 32'(size_err), 32'd1);

    // following full load clears it, then abort in the middle of the clear
    dl = 1'b1;
    tick();
    load_bytes(EXP_SIZE);
    dl = 1'b0;
    tick();
    check("reload_size_err", 32'(size_err), 32'd0);
    for (int k = 0; k < 2000 && wram_addr != 10'd500; k++) tick();
    check("reach_wram_500", 32'(wram_addr), 32'd500);
    dl = 1'b1;
    tick();
    check("abort_wram_wr", 32'(wram_wr), 32'd0);
    check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
    check("abort_load_done", 32'(load_done), 32'd0);
    wr = 1'b1; addr = 25'h14000; data = 8'h5A;
    tick();
    wr = 1'b0;
    check("abort_in_load_rom_wr", 32'(rom_wr), 32'd1);
    check("abort_in_load_region", 32'(region), 32'd2);
    tick();

    // last byte coincides with the download dropping: still written and counted
    for (int i = 1; i < EXP_SIZE - 1; i++) strobe(25'(i), 8'(i));
    wr = 1'b1; dl = 1'b0; addr = 25'h1ABCD; data = 8'hC3;
    tick();
    wr = 1'b0;
    check("coinc_rom_wr", 32'(rom_wr), 32'd1);
    check("coinc_rom_data", 32'(rom_data), 32'hC3);
    check("coinc_region", 32'(region), 32'd7);
    check("coinc_wram_wr", 32'(wram_wr), 32'd1);
    check("coinc_size_err", 32'(size_err), 32'd0);
    wait_run(p, s);

    // reset mid-load, with a strobe in the same cycle
    dl = 1'b1;
    tick();
    load_bytes('h50);
    reset = 1'b1; wr = 1'b1; addr = 25'h123; data = 8'h77;
    tick();
    check_reset_values("midload_rst");
    reset = 1'b0; dl = 1'b0; addr = 25'd9;
    tick();
    check("post_rst_wr_ignored", 32'(rom_wr), 32'd0);
    wr = 1'b0;
    tick();
    check("post_rst_idle_cpu_reset", 32'(cpu_reset), 32'd1);
    check("post_rst_idle_wram_wr", 32'(wram_wr), 32'd0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
